// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch stage
package fetch_pkg;
    localparam int FETCH_XLEN = 32;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int PC_STEP = 4;
    typedef enum logic [1:0] {ISSUE, WAIT, DROP} fetch_state_e;
    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch FIFO with synchronous clear and occupancy count
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type T = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  T                         wdata,
    input  logic                     pop,
    output T                         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [AW-1:0] wr, rd;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else if (clear) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr] <= wdata;
    end
    assign rdata = mem[rd];
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-outstanding fetches into a prefetch FIFO,
// with flush/redirect and interrupt-instruction injection.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int BUF_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int PC_STEP = fetch_pkg::PC_STEP
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_done,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_next,
    input  logic            INT,
    input  logic [XLEN-1:0] INT_INST,
    output logic            ACK
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;
    fetch_state_e state, state_nxt;
    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0] count;
    logic int_armed, inject, push, pop, full, empty;
    entry_t head;
    fetch_fifo #(.DEPTH(BUF_DEPTH), .T(entry_t)) u_fifo (
        .clk(clk),
        .rst(rst),
        .clear(flush),
        .push(push),
        .wdata('{pc: fetch_pc, instr: mem_rdata}),
        .pop(pop),
        .rdata(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ISSUE;
        else state <= state_nxt;
    end
    // a flushed request still owes a response, which DROP swallows
    always_comb begin
        state_nxt = state;
        if (flush) state_nxt = (state != ISSUE && !mem_done) ? DROP : ISSUE;
        else if (state == ISSUE) state_nxt = mem_req ? WAIT : ISSUE;
        else if (mem_done) state_nxt = ISSUE;
    end
    // the slot for the outstanding fetch is reserved by issuing only below DEPTH
    always_comb begin
        mem_req = state == ISSUE && count != CW'(BUF_DEPTH) && !flush && !rst;
        mem_addr = fetch_pc;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fetch_pc <= RESET_PC;
        else if (flush) fetch_pc <= redirect_pc;
        else if (push) fetch_pc <= fetch_pc + STEP;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) int_armed <= 1'b1;
        else if (!INT) int_armed <= 1'b1;
        else if (ACK) int_armed <= 1'b0;
    end
    assign inject = INT && int_armed && !flush && !rst;
    assign push = state == WAIT && mem_done && !flush;
    assign pop = !empty && instr_ready && !inject && !flush;
    assign instr_valid = inject || !empty;
    assign instr = inject ? INT_INST : empty ? '0 : head.instr;
    assign out_pc = !empty ? head.pc : inject ? fetch_pc : '0;
    assign out_pc_next = out_pc + STEP;
    assign ACK = inject && instr_ready;
    assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch, buffering, flush, injection and PC wrap
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst, flush, mem_req, mem_done, instr_valid, instr_ready, INT, ACK;
    logic [31:0] redirect_pc, mem_addr, mem_rdata, instr, out_pc, out_pc_next, INT_INST;
    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] log_q[$];
    bit busy = 1'b0;
    int cnt = 0;
    int acks;
    logic [31:0] maddr;

    fetch_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .out_pc(out_pc), .out_pc_next(out_pc_next), .INT(INT), .INT_INST(INT_INST), .ACK(ACK)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!instr_valid && n < 40) begin
            tick();
            n++;
        end
        if (!instr_valid) check("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] pc);
        wait_valid();
        check({tag, "_pc"}, out_pc, pc);
        check({tag, "_instr"}, instr, data_of(pc));
        check({tag, "_pc_next"}, out_pc_next, pc + 32'd4);
    endtask

    // memory model: accepts a request at the clock edge, answers two cycles later
    initial forever begin
        @(posedge clk);
        if (rst) busy = 1'b0;
        else if (!busy && mem_req) begin
            busy = 1'b1;
            cnt = 2;
            maddr = mem_addr;
            log_q.push_back(mem_addr);
        end
    end

    initial begin
        mem_done = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (rst) busy = 1'b0;
            else if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    mem_done = 1'b1;
                    mem_rdata = data_of(maddr);
                    busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        INT = 1'b0; INT_INST = '0;
        tick(); tick();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_ack", 32'(ACK), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_out_pc", out_pc, 32'd0);
        rst = 1'b0; instr_ready = 1'b1;
        #1;
        check("first_req", 32'(mem_req), 32'd1);
        check("first_addr", mem_addr, 32'd0);
        // sequential fetch
        for (int k = 0; k < 4; k++) begin
            expect_instr("seq", 32'(4 * k));
            tick();
        end
        for (int k = 0; k < 4; k++) check("seq_addr", log_q[k], 32'(4 * k));
        // stall fills the buffer and stops fetching
        instr_ready = 1'b0;
        repeat (15) tick();
        check("stall_req", 32'(mem_req), 32'd0);
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_reqs", 32'(log_q.size()), 32'd8);
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            expect_instr("drain", 32'h10 + 32'(4 * k));
            tick();
        end
        instr_ready = 1'b0;
        expect_instr("resume", 32'h20);
        // interrupt injection with head at 0x20
        INT = 1'b1; INT_INST = 32'hDEAD_BEEF;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("inj_hold_ack", 32'(ACK), 32'd0);
            check("inj_hold_instr", instr, 32'hDEAD_BEEF);
            check("inj_hold_pc", out_pc, 32'h20);
            tick();
        end
        instr_ready = 1'b1;
        #1;
        check("inj_ack", 32'(ACK), 32'd1);
        check("inj_instr", instr, 32'hDEAD_BEEF);
        check("inj_pc", out_pc, 32'h20);
        check("inj_pc_next", out_pc_next, 32'h24);
        tick();
        check("post_inj_ack", 32'(ACK), 32'd0);
        check("post_inj_instr", instr, data_of(32'h20));
        check("post_inj_pc", out_pc, 32'h20);
        tick();
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            acks += int'(ACK);
            tick();
        end
        check("no_reinject", 32'(acks), 32'd0);
        INT = 1'b0;
        tick();
        // flush while the request to 0x8 is outstanding
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; instr_ready = 1'b0;
        begin
            int n = 0;
            while (!(mem_req && mem_addr == 32'h8) && n < 40) begin
                tick();
                n++;
            end
        end
        check("req8", mem_addr, 32'h8);
        tick();
        check("pre_flush_valid", 32'(instr_valid), 32'd1);
        check("pre_flush_pc", out_pc, 32'h0);
        flush = 1'b1; redirect_pc = 32'h100;
        tick();
        flush = 1'b0; instr_ready = 1'b1;
        #1;
        check("flush_valid", 32'(instr_valid), 32'd0);
        check("flush_drop_req", 32'(mem_req), 32'd0);
        tick();
        check("redirect_req", 32'(mem_req), 32'd1);
        check("redirect_addr", mem_addr, 32'h100);
        expect_instr("redirect", 32'h100);
        tick();
        // injection held, then cancelled by a flush
        instr_ready = 1'b0; INT = 1'b1; INT_INST = 32'h1234_5678;
        #1;
        for (int k = 0; k < 3; k++) begin
            check("hold_ack", 32'(ACK), 32'd0);
            check("hold_valid", 32'(instr_valid), 32'd1);
            check("hold_instr", instr, 32'h1234_5678);
            check("hold_pc", out_pc, 32'h104);
            tick();
        end
        flush = 1'b1; redirect_pc = 32'hFFFF_FFF8; instr_ready = 1'b1;
        #1;
        check("flush_ack", 32'(ACK), 32'd0);
        tick();
        flush = 1'b0; INT = 1'b0;
        #1;
        check("cancel_ack", 32'(ACK), 32'd0);
        check("cancel_valid", 32'(instr_valid), 32'd0);
        // PC wraps modulo 2^32
        expect_instr("wrap0", 32'hFFFF_FFF8);
        tick();
        expect_instr("wrap1", 32'hFFFF_FFFC);
        tick();
        expect_instr("wrap2", 32'h0000_0000);
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
